ceespu_store_unit: RTL
======================

Name: ceespu_store_unit

Overview:
- Write-side counterpart of the execute stage's load-data extraction.
- Accepts a store from execute (word address, 32-bit data, I_selMem lane/size code) and steers the data onto the correct byte lanes.
- Generates byte enables and drives a req/ack handshake to data memory; stalls the pipeline via O_busy until the memory acknowledges.

Parameters:
- ADDR_W, 14, width of the data-memory word address.
- TIMEOUT_CYCLES, 255, cycles to wait for I_mem_ack before aborting. Used only with CEESPU_STORE_TIMEOUT_EN.

Ports:
- I_clk  in  1  clock; all state updates on rising edge.
- I_rst  in  1  reset, asynchronous, active-low.
- I_valid  in  1  store request from execute, sampled when O_busy=0.
- I_addr  in  ADDR_W  word address.
- I_data  in  32  store data, right-aligned.
- I_selMem  in  4  size/lane code; bit3 (sign) ignored for stores.
- I_mem_ack  in  1  memory has committed the write.
- O_mem_req  out  1  write request to memory.
- O_mem_addr  out  ADDR_W  registered word address.
- O_mem_wdata  out  32  lane-steered data.
- O_mem_we  out  4  byte enables; bit n = byte lane n (bits 8n+7:8n).
- O_busy  out  1  stall to pipeline, combinational.
- O_done  out  1  one-cycle pulse when a store completes.
- O_fault  out  1  one-cycle pulse when a store is aborted on timeout.

Behaviour:
- Reset (I_rst=0, async): state=IDLE. O_mem_req, O_mem_addr, O_mem_wdata, O_mem_we, O_done and O_fault all 0. Any in-flight request is dropped with no O_done.
- Lane steering from I_selMem[2:0]:
  - 000/001: word; wdata=I_data, we=1111.
  - 010: low half; wdata={I_data[15:0],I_data[15:0]}, we=0011.
  - 011: high half; same wdata, we=1100.
  - 1nn: byte lane nn; wdata=I_data[7:0] replicated 4x, we=0001<<nn.
- States: IDLE and REQ.
- IDLE:
  - I_valid=1 → register addr, wdata and we; O_mem_req=1; next state REQ.
  - Latency: request visible the cycle after I_valid.
- REQ:
  - O_mem_req, addr, wdata and we are held stable until acknowledged.
  - I_mem_ack=1 → O_done=1 for the next cycle.
  - If I_valid is also 1 in the same cycle, the new store is captured back-to-back and the state stays REQ; otherwise O_mem_req=0 and the state goes to IDLE.
- O_busy = (state==REQ) & !I_mem_ack.
  - Upstream must hold I_valid and its operands while O_busy=1.
  - I_valid is ignored while O_busy=1.
- I_mem_ack in IDLE is ignored: no O_done, no state change.
- O_mem_we is 0000 whenever O_mem_req=0.
- Throughput: one store per cycle if memory acks in the same cycle as req; each extra wait cycle adds one stall cycle.

Optional Feature:
- Macro CEESPU_STORE_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter, sized from TIMEOUT_CYCLES, clears on entry to REQ and counts each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: O_mem_req drops, state goes to IDLE, O_fault=1 for one cycle, O_done stays 0.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no fault.
- Undefined: no counter; REQ waits indefinitely; O_fault is tied to 0.

Decomposition:
- Shared package ceespu_pkg holds:
  - I_selMem encoding constants: SELMEM_WORD, SELMEM_HALF_LO, SELMEM_HALF_HI, SELMEM_BYTE0..3. The execute-stage load extraction uses the same constants.
  - Store FSM state enum (ST_IDLE, ST_REQ).
  - Byte-enable constants (BE_WORD=4'b1111, etc.).
- Sub-module ceespu_store_align: purely combinational lane steering (I_selMem, I_data → wdata, we). Reusable by a future load/store merge unit.

Test Plan:
- Reset mid-REQ:
  - Issue store, assert I_rst=0 while waiting for ack.
  - Outputs go 0 immediately (async); state IDLE; no O_done after release.
- Word store, immediate ack:
  - I_valid=1, addr=0x12, data=0xDEADBEEF, selMem=0000; ack in the first REQ cycle.
  - Next cycle: req=1, addr=0x12, wdata=0xDEADBEEF, we=1111.
  - O_busy=0 that cycle; O_done pulses once.
- Byte lane with wait states:
  - data=0x000000A5, selMem=0110; ack after 3 cycles.
  - wdata=0xA5A5A5A5, we=0100 held stable for 3 cycles; O_busy=1 for 2 cycles, 0 in the ack cycle.
- Half-high store plus back-to-back:
  - selMem=1011, data=0x1234 acked in the same cycle a second I_valid arrives (selMem=0010, data=0xBEEF).
  - First store: wdata=0x12341234, we=1100.
  - Second store immediately after: wdata=0xBEEFBEEF, we=0011; req stays 1; two O_done pulses.
- Timeout (macro defined, TIMEOUT_CYCLES=4):
  - Store with no ack: req drops after 4 REQ cycles, O_fault=1 for 1 cycle, O_done=0.
  - Repeat with ack on cycle 4: O_done=1, O_fault=0.

Source files
------------

// File: rtl/ceespu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ceespu_pkg
// Purpose : Shared definitions for the ceespu memory stage. Holds the
//           I_selMem lane/size codes (also used by the execute-stage load
//           extraction), store byte-enable patterns, the store FSM state
//           type and a helper that sizes the optional timeout counter.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ceespu_pkg;

  // I_selMem[2:0] lane/size codes; bit 3 is the load sign flag.
  localparam logic [2:0] SELMEM_WORD     = 3'b000;
  localparam logic [2:0] SELMEM_WORD_ALT = 3'b001;
  localparam logic [2:0] SELMEM_HALF_LO  = 3'b010;
  localparam logic [2:0] SELMEM_HALF_HI  = 3'b011;
  localparam logic [2:0] SELMEM_BYTE0    = 3'b100;
  localparam logic [2:0] SELMEM_BYTE1    = 3'b101;
  localparam logic [2:0] SELMEM_BYTE2    = 3'b110;
  localparam logic [2:0] SELMEM_BYTE3    = 3'b111;

  // Byte enables: bit n selects data bits 8n+7:8n.
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } store_state_t;

  // Timeout counter width: enough bits for the limit, clamped to 8..16.
  function automatic int timeout_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ceespu_store_align.sv
`default_nettype none
// ============================================================================
// Module  : ceespu_store_align
// Purpose : Combinational store lane steering. Replicates right-aligned
//           store data across the lanes of a 32-bit word and produces the
//           matching byte enables.
// Ports   : I_sel[2:0]  lane/size code (I_selMem without the sign bit)
//           I_data[31:0] right-aligned store data
//           O_wdata[31:0] lane-steered write data
//           O_we[3:0]    byte enables
// Rev     : 1.0  initial release
// ============================================================================
module ceespu_store_align
  import ceespu_pkg::*;
(
  input  logic [2:0]  I_sel,
  input  logic [31:0] I_data,
  output logic [31:0] O_wdata,
  output logic [3:0]  O_we
);

  logic [31:0] w_half;
  logic [31:0] w_byte;

  // Replication means the memory sees the right value whichever lane the
  // enables select, so no shifter is needed.
  assign w_half = {2{I_data[15:0]}};
  assign w_byte = {4{I_data[7:0]}};

  always_comb begin
    O_wdata = I_data;
    O_we    = BE_WORD;
    case (I_sel)
      SELMEM_WORD, SELMEM_WORD_ALT: begin
        O_wdata = I_data;
        O_we    = BE_WORD;
      end
      SELMEM_HALF_LO: begin
        O_wdata = w_half;
        O_we    = BE_HALF_LO;
      end
      SELMEM_HALF_HI: begin
        O_wdata = w_half;
        O_we    = BE_HALF_HI;
      end
      SELMEM_BYTE0: begin
        O_wdata = w_byte;
        O_we    = BE_BYTE0;
      end
      SELMEM_BYTE1: begin
        O_wdata = w_byte;
        O_we    = BE_BYTE1;
      end
      SELMEM_BYTE2: begin
        O_wdata = w_byte;
        O_we    = BE_BYTE2;
      end
      SELMEM_BYTE3: begin
        O_wdata = w_byte;
        O_we    = BE_BYTE3;
      end
      default: begin
        O_wdata = I_data;
        O_we    = BE_WORD;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ceespu_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : ceespu_store_unit
// Purpose : Store path to data memory. Captures a store from execute,
//           steers it onto byte lanes, and runs a req/ack handshake while
//           stalling the pipeline through O_busy.
// Config  : `define CEESPU_STORE_TIMEOUT_EN to abort requests that are not
//           acknowledged within TIMEOUT_CYCLES cycles (O_fault pulse).
// Ports   : I_clk, I_rst (async, active-low)
//           I_valid/I_addr/I_data/I_selMem  store from execute
//           I_mem_ack                        memory write committed
//           O_mem_req/O_mem_addr/O_mem_wdata/O_mem_we  memory request
//           O_busy  pipeline stall (combinational)
//           O_done  completion pulse, O_fault  timeout-abort pulse
// Rev     : 1.0  initial release
// ============================================================================
module ceespu_store_unit
  import ceespu_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_valid,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [31:0]       I_data,
  input  logic [3:0]        I_selMem,
  input  logic              I_mem_ack,
  output logic              O_mem_req,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [31:0]       O_mem_wdata,
  output logic [3:0]        O_mem_we,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_fault
);

  store_state_t      r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_we;
  logic              r_done;
  logic              r_fault;

  logic [31:0]       w_wdata;
  logic [3:0]        w_we;
  logic              w_busy;
  logic              w_load;
  logic              w_ack_req;
  logic              w_unused_sign;

  // The sign bit only matters for loads.
  assign w_unused_sign = I_selMem[3];

  ceespu_store_align u_align (
    .I_sel   (I_selMem[2:0]),
    .I_data  (I_data),
    .O_wdata (w_wdata),
    .O_we    (w_we)
  );

  assign w_ack_req = (r_state == ST_REQ) & I_mem_ack;
  assign w_busy    = (r_state == ST_REQ) & ~I_mem_ack;
  // An ack frees the unit in the same cycle, so a waiting store is taken
  // immediately (back-to-back).
  assign w_load    = I_valid & ~w_busy;

`ifdef CEESPU_STORE_TIMEOUT_EN
  localparam int c_CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_timeout;

  // r_cnt holds the number of unacknowledged REQ cycles already elapsed;
  // the last permitted cycle aborts unless an ack arrives in it.
  assign w_timeout = (r_state == ST_REQ) & ~I_mem_ack & (r_cnt == c_TO_LAST);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= BE_NONE;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
`ifdef CEESPU_STORE_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_done  <= w_ack_req;
      r_fault <= 1'b0;
      if (w_load) begin
        r_state <= ST_REQ;
        r_req   <= 1'b1;
        r_addr  <= I_addr;
        r_wdata <= w_wdata;
        r_we    <= w_we;
`ifdef CEESPU_STORE_TIMEOUT_EN
        r_cnt   <= '0;
`endif
      end else if (w_ack_req) begin
        r_state <= ST_IDLE;
        r_req   <= 1'b0;
        r_we    <= BE_NONE;
      end
`ifdef CEESPU_STORE_TIMEOUT_EN
      else if (w_timeout) begin
        r_state <= ST_IDLE;
        r_req   <= 1'b0;
        r_we    <= BE_NONE;
        r_fault <= 1'b1;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
    end
  end

  assign O_mem_req   = r_req;
  assign O_mem_addr  = r_addr;
  assign O_mem_wdata = r_wdata;
  assign O_mem_we    = r_we;
  assign O_busy      = w_busy;
  assign O_done      = r_done;
  assign O_fault     = r_fault;

endmodule
`default_nettype wire
